// File: rtl/ifu_param_if.sv
// Fetch-unit bus: instruction-memory write port, PC redirect request and the
// instruction stream handshake towards decode.
interface ifu_param_if #(
    parameter int XLEN    = 32,
    parameter int INSTR_W = 32,
    parameter int AW      = 6
);
    logic               imem_we;
    logic [AW-1:0]      imem_waddr;
    logic [INSTR_W-1:0] imem_wdata;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               instr_ready;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    instr_pc;

    // master: the core side that loads memory, steers the PC and consumes instructions
    modport master (
        output imem_we, imem_waddr, imem_wdata, redirect_valid, redirect_pc, instr_ready,
        input  instr_valid, instr, instr_pc
    );

    // slave: the fetch unit itself
    modport slave (
        input  imem_we, imem_waddr, imem_wdata, redirect_valid, redirect_pc, instr_ready,
        output instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/ifu_param.sv
// Parametrised instruction fetch unit: PC, loadable instruction memory, valid/ready
// stream with stall, redirect, halt word and sticky fault. IFU_PERF_CNT_EN adds counters.
module ifu_param #(
    parameter int                 XLEN       = 32,
    parameter int                 INSTR_W    = 32,
    parameter int                 IMEM_DEPTH = 64,
    parameter logic [XLEN-1:0]    RESET_PC   = {XLEN{1'b0}},
    parameter logic [INSTR_W-1:0] HALT_ENC   = {INSTR_W{1'b1}}
) (
    input  logic            CLOCK,
    input  logic            RESET,
    ifu_param_if.slave      bus,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0]     fetch_count,
    output logic [31:0]     stall_count,
`endif
    output logic            fault,
    output logic [XLEN-1:0] fault_pc
);
    localparam int              AW         = $clog2(IMEM_DEPTH);
    localparam int              BYTES      = INSTR_W / 8;
    localparam int              S          = $clog2(BYTES);
    localparam logic [XLEN:0]   PC_LIMIT   = (XLEN + 1)'(IMEM_DEPTH * BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(BYTES - 1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(BYTES);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // A fetch address must be word aligned and inside the instruction memory.
    function automatic logic pc_ok(input logic [XLEN-1:0] p);
        return ((p & ALIGN_MASK) == {XLEN{1'b0}}) && ({1'b0, p} < PC_LIMIT);
    endfunction

    logic [INSTR_W-1:0] imem_r [IMEM_DEPTH];

    state_t             state_r, state_s;
    logic [XLEN-1:0]    pc_r, pc_s;
    logic               instr_valid_r, instr_valid_s;
    logic [INSTR_W-1:0] instr_r, instr_s;
    logic [XLEN-1:0]    instr_pc_r, instr_pc_s;
    logic               fault_r, fault_s;
    logic [XLEN-1:0]    fault_pc_r, fault_pc_s;
    logic               load_s;
    logic [INSTR_W-1:0] rd_word_s;

    // Write port; reads are combinational so a same-edge write/load sees the old word.
    always_ff @(posedge CLOCK) begin
        if (bus.imem_we) begin
            imem_r[bus.imem_waddr] <= bus.imem_wdata;
        end
    end

    assign load_s    = (state_r == ST_RUN) && (!instr_valid_r || bus.instr_ready);
    assign rd_word_s = imem_r[pc_r[AW+S-1:S]];

    // Next-state logic: fault detection, then redirect, then slot load.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        instr_valid_s = instr_valid_r;
        instr_s       = instr_r;
        instr_pc_s    = instr_pc_r;
        fault_s       = fault_r;
        fault_pc_s    = fault_pc_r;
        case (state_r)
            ST_RUN, ST_HALT: begin
                if (bus.redirect_valid && !pc_ok(bus.redirect_pc)) begin
                    state_s       = ST_FAULT;
                    fault_s       = 1'b1;
                    fault_pc_s    = bus.redirect_pc;
                    instr_valid_s = 1'b0;
                end else if (load_s && !pc_ok(pc_r)) begin
                    state_s       = ST_FAULT;
                    fault_s       = 1'b1;
                    fault_pc_s    = pc_r;
                    instr_valid_s = 1'b0;
                end else if (bus.redirect_valid) begin
                    state_s       = ST_RUN;
                    pc_s          = bus.redirect_pc;
                    instr_valid_s = 1'b0;
                end else if (load_s) begin
                    instr_s       = rd_word_s;
                    instr_pc_s    = pc_r;
                    instr_valid_s = 1'b1;
                    pc_s          = pc_r + PC_STEP;
                    if (rd_word_s == HALT_ENC) begin
                        state_s = ST_HALT;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else if (instr_valid_r && bus.instr_ready) begin
                    // halted: the halt word has been taken and nothing follows it
                    instr_valid_s = 1'b0;
                end else begin
                    instr_valid_s = instr_valid_r;
                end
            end
            ST_FAULT: begin
                instr_valid_s = 1'b0;
            end
            default: begin
                state_s       = ST_FAULT;
                fault_s       = 1'b1;
                fault_pc_s    = pc_r;
                instr_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_r       <= ST_RUN;
            pc_r          <= RESET_PC;
            instr_valid_r <= 1'b0;
            instr_r       <= {INSTR_W{1'b0}};
            instr_pc_r    <= {XLEN{1'b0}};
            fault_r       <= 1'b0;
            fault_pc_r    <= {XLEN{1'b0}};
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            instr_valid_r <= instr_valid_s;
            instr_r       <= instr_s;
            instr_pc_r    <= instr_pc_s;
            fault_r       <= fault_s;
            fault_pc_r    <= fault_pc_s;
        end
    end

    assign bus.instr_valid = instr_valid_r;
    assign bus.instr       = instr_r;
    assign bus.instr_pc    = instr_pc_r;
    assign fault           = fault_r;
    assign fault_pc        = fault_pc_r;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_count_r, stall_count_r;

    // Saturating handshake counters: accepted instructions and stalled cycles.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            fetch_count_r <= 32'd0;
            stall_count_r <= 32'd0;
        end else begin
            if (instr_valid_r && bus.instr_ready && (fetch_count_r != 32'hFFFF_FFFF)) begin
                fetch_count_r <= fetch_count_r + 32'd1;
            end
            if (instr_valid_r && !bus.instr_ready && (stall_count_r != 32'hFFFF_FFFF)) begin
                stall_count_r <= stall_count_r + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_count_r;
    assign stall_count = stall_count_r;
`endif
endmodule
